// File: rtl/memory_access.sv
// Memory-access stage: passes ALU results through, or issues one data-bus
// request per load/store and formats the load data for writeback.
module memory_access (
    input  logic        clk,
    input  logic        resetn,
    // execute-stage slot-1 result
    input  logic        in_valid,
    input  logic        in_memread,
    input  logic        in_memwrite,
    input  logic [1:0]  in_msize,
    input  logic        in_signext,
    input  logic [31:0] in_aluout,
    input  logic [31:0] in_wdata,
    input  logic        in_exc,
    input  logic        in_regwrite,
    input  logic [4:0]  in_dst,
    input  logic        flush,
    output logic        stall,
    // data bus
    output logic        req,
    output logic [31:0] req_addr,
    output logic [3:0]  req_wstrb,
    output logic [31:0] req_wdata,
    output logic [1:0]  req_size,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    // writeback
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_regwrite,
    output logic [4:0]  out_dst,
    // FSM state: 0=IDLE, 1=REQ, 2=WAIT, 3=DRAIN
    output logic [1:0]  dbg_state_o
);

    // Handshakes: an op is taken when in_valid && !stall && !flush; the bus
    // takes the request on a cycle with req && addr_ok, and returns one
    // data_ok per taken request in a later cycle. out_valid is a one-cycle
    // pulse with no backpressure.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic        accept;
    logic        is_mem;
    logic        start_mem;
    logic        pass_thru;
    logic        mem_done;

    logic [31:0] addr_fmt;
    logic [3:0]  wstrb_fmt;
    logic [31:0] wdata_fmt;
    logic [31:0] load_fmt;

    logic [31:0] req_addr_q;
    logic [3:0]  req_wstrb_q;
    logic [31:0] req_wdata_q;
    logic [1:0]  req_size_q;
    logic        ld_q;
    logic        ld_signext_q;
    logic [1:0]  ld_lane_q;
    logic [31:0] aluout_q;
    logic        regwrite_q;
    logic [4:0]  dst_q;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_regwrite_q, out_regwrite_d;
    logic [4:0]  out_dst_q, out_dst_d;

    function automatic logic [3:0] store_strobe(input logic [1:0] size,
                                                input logic [1:0] lane);
        logic [3:0] s;
        case (size)
            2'd0:    s = 4'b0001 << lane;
            2'd1:    s = 4'b0011 << {lane[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0]  size,
                                               input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'd0:    r = {4{d[7:0]}};
            2'd1:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] d,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{lane, 3'b000} +: 8];
        h = lane[1] ? d[31:16] : d[15:0];
        case (size)
            2'd0:    r = {{24{sx & b[7]}}, b};
            2'd1:    r = {{16{sx & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign accept    = in_valid && !stall && !flush;
    assign is_mem    = in_memread || in_memwrite;
    assign start_mem = accept && is_mem && !in_exc;
    // An excepting memory op behaves like an ALU op with its write suppressed.
    assign pass_thru = accept && !(is_mem && !in_exc);

    assign addr_fmt  = (in_msize[1]) ? {in_aluout[31:2], 2'b00} : in_aluout;
    assign wstrb_fmt = in_memwrite ? store_strobe(in_msize, in_aluout[1:0]) : 4'b0000;
    assign wdata_fmt = store_data(in_msize, in_wdata);
    assign load_fmt  = load_extend(rdata, req_size_q, ld_lane_q, ld_signext_q);

    always_comb begin
        state_d  = state_q;
        mem_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_mem) state_d = S_REQ;
            end
            S_REQ: begin
                if (flush)        state_d = addr_ok ? S_DRAIN : S_IDLE;
                else if (addr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A flush landing with data_ok already has its response, so
                // there is nothing left to drain.
                if (data_ok) begin
                    state_d  = S_IDLE;
                    mem_done = !flush;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d    = pass_thru || mem_done;
        out_regwrite_d = 1'b0;
        out_data_d     = out_data_q;
        out_dst_d      = out_dst_q;
        if (pass_thru) begin
            out_data_d     = in_aluout;
            out_regwrite_d = in_regwrite && !in_exc;
            out_dst_d      = in_dst;
        end else if (mem_done) begin
            out_data_d     = ld_q ? load_fmt : aluout_q;
            out_regwrite_d = ld_q && regwrite_q;
            out_dst_d      = dst_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            out_valid_q    <= 1'b0;
            out_data_q     <= 32'h0;
            out_regwrite_q <= 1'b0;
            out_dst_q      <= 5'd0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_regwrite_q <= out_regwrite_d;
            out_dst_q      <= out_dst_d;
        end
    end

    // Request and load-format context captured at accept; upstream may move
    // on once stall drops, so nothing here reads the live inputs later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_addr_q   <= 32'h0;
            req_wstrb_q  <= 4'b0000;
            req_wdata_q  <= 32'h0;
            req_size_q   <= 2'd0;
            ld_q         <= 1'b0;
            ld_signext_q <= 1'b0;
            ld_lane_q    <= 2'd0;
            aluout_q     <= 32'h0;
            regwrite_q   <= 1'b0;
            dst_q        <= 5'd0;
        end else if (start_mem) begin
            req_addr_q   <= addr_fmt;
            req_wstrb_q  <= wstrb_fmt;
            req_wdata_q  <= wdata_fmt;
            req_size_q   <= in_msize;
            ld_q         <= in_memread;
            ld_signext_q <= in_signext;
            ld_lane_q    <= in_aluout[1:0];
            aluout_q     <= in_aluout;
            regwrite_q   <= in_regwrite;
            dst_q        <= in_dst;
        end
    end

    assign stall        = (state_q != S_IDLE);
    assign req          = (state_q == S_REQ);
    assign req_addr     = req_addr_q;
    assign req_wstrb    = req_wstrb_q;
    assign req_wdata    = req_wdata_q;
    assign req_size     = req_size_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_regwrite = out_regwrite_q;
    assign out_dst      = out_dst_q;
    assign dbg_state_o  = state_q;

endmodule
